// File: rtl/alu_seq_ctrl.sv
// Four-cycle instruction sequencer and 8x16 register file in front of the 16-bit combinational ALU.
// Optional feature macro ALU_SEQ_ILLEGAL_TRAP_EN: an illegal op index parks the FSM in HALT until reset.
module alu_seq_ctrl #(
    parameter int unsigned NREGS   = 8,
    parameter logic [4:0]  RST_PSR = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned K_W    = 5;

    localparam logic [OP_W-1:0] OPC_NOP = 8'hB0;

    localparam logic [K_W-1:0] K_ADDI   = 5'd1;
    localparam logic [K_W-1:0] K_ADDUI  = 5'd3;
    localparam logic [K_W-1:0] K_ADDCUI = 5'd6;
    localparam logic [K_W-1:0] K_ADDCI  = 5'd7;
    localparam logic [K_W-1:0] K_SUBI   = 5'd9;
    localparam logic [K_W-1:0] K_CMP    = 5'd10;
    localparam logic [K_W-1:0] K_CMPI   = 5'd11;
    localparam logic [K_W-1:0] K_LSHI   = 5'd17;
    localparam logic [K_W-1:0] K_RSHI   = 5'd19;
    localparam logic [K_W-1:0] K_NOP    = 5'd22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_instr;
    logic [OP_W-1:0]       r_opcode;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [DATA_W-1:0]     r_c;
    logic [FLAG_W-1:0]     r_flags;
    logic [FLAG_W-1:0]     r_psr;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_illegal;
    logic [DATA_W-1:0]     r_regs [NREGS];

    logic                  w_ready_nxt;
    logic                  w_done_nxt;
    logic                  w_illegal_nxt;
    logic                  w_load_instr;
    logic                  w_load_ops;
    logic                  w_capture;
    logic                  w_wb;

    logic [K_W-1:0]        w_k;
    logic [IDX_W-1:0]      w_rd;
    logic [IDX_W-1:0]      w_rs;
    logic [7:0]            w_imm;
    logic                  w_legal;
    logic                  w_wr_en;
    logic                  w_psr_en;
    logic [DATA_W-1:0]     w_b_sel;

    assign w_k   = r_instr[15:11];
    assign w_rd  = r_instr[10:8];
    assign w_rs  = r_instr[7:5];
    assign w_imm = r_instr[7:0];

    assign w_legal  = (w_k <= K_NOP);
    assign w_wr_en  = w_legal && (w_k != K_CMP) && (w_k != K_CMPI) && (w_k != K_NOP);
    assign w_psr_en = w_legal && (w_k != K_NOP);

    // Operand B: register, sign/zero-extended immediate, or 4-bit shift amount
    always_comb begin
        w_b_sel = r_regs[w_rs];
        case (w_k)
            K_ADDI, K_ADDCI, K_SUBI, K_CMPI: w_b_sel = {{8{w_imm[7]}}, w_imm};
            K_ADDUI, K_ADDCUI:               w_b_sel = {8'h00, w_imm};
            K_LSHI, K_RSHI:                  w_b_sel = {12'h000, w_imm[3:0]};
            default:                         w_b_sel = r_regs[w_rs];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ready_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_load_instr  = 1'b0;
        w_load_ops    = 1'b0;
        w_capture     = 1'b0;
        w_wb          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (instr_valid && r_ready) begin
                    w_state_nxt  = S_DECODE;
                    w_ready_nxt  = 1'b0;
                    w_load_instr = 1'b1;
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXEC;
                w_load_ops  = 1'b1;
            end
            S_EXEC: begin
                w_state_nxt   = S_WB;
                w_capture     = 1'b1;
                w_done_nxt    = w_legal;
                w_illegal_nxt = !w_legal;
            end
            S_WB: begin
                w_wb = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                if (w_legal) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_HALT;
                end
`else
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
`endif
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and register file; reset aborts any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_opcode  <= OPC_NOP;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_flags   <= '0;
            r_psr     <= RST_PSR;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[IDX_W'(i)] <= '0;
        end else begin
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            if (w_load_instr) r_instr <= instr;
            if (w_load_ops) begin
                r_opcode <= w_legal ? {w_k, 3'b000} : OPC_NOP;
                r_a      <= r_regs[w_rd];
                r_b      <= w_b_sel;
            end
            if (w_capture) begin
                r_c     <= alu_c;
                r_flags <= alu_flags;
            end
            if (w_wb && w_wr_en)  r_regs[w_rd] <= r_c;
            if (w_wb && w_psr_en) r_psr        <= r_flags;
        end
    end

    assign instr_ready = r_ready;
    assign alu_opcode  = r_opcode;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign psr         = r_psr;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; the bench plays the ALU by driving alu_c/alu_flags per instruction.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks;
    int n_fail;

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!instr_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 16'(instr_ready), 16'h0001);
    endtask

    // Issue one instruction and follow it through DECODE, EXEC, WB back to IDLE
    task automatic issue(input string tag, input logic [15:0] iw,
                         input logic [15:0] c, input logic [4:0] fl,
                         input logic [7:0] e_opc, input logic [15:0] e_a, input logic [15:0] e_b,
                         input logic e_done, input logic e_ill);
        wait_ready({tag, "_ready"});
        instr_valid = 1'b1;
        instr       = iw;
        @(posedge clk); #1;
        check({tag, "_busy"}, 16'(instr_ready), 16'h0000);
        instr = 16'hFFFF;
        @(posedge clk); #1;
        check({tag, "_opc"}, 16'(alu_opcode), 16'(e_opc));
        check({tag, "_a"}, alu_a, e_a);
        check({tag, "_b"}, alu_b, e_b);
        alu_c     = c;
        alu_flags = fl;
        @(posedge clk); #1;
        check({tag, "_done"}, 16'(done), 16'(e_done));
        check({tag, "_ill"}, 16'(illegal), 16'(e_ill));
        instr_valid = 1'b0;
        alu_c       = 16'hDEAD;
        alu_flags   = 5'b01010;
        @(posedge clk); #1;
        check({tag, "_done_off"}, 16'(done), 16'h0000);
        check({tag, "_ill_off"}, 16'(illegal), 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        alu_c       = 16'h0000;
        alu_flags   = 5'b00000;
        dbg_addr    = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 16'(instr_ready), 16'h0000);
        check("rst_psr", 16'(psr), 16'h0000);
        check("rst_opc", 16'(alu_opcode), 16'h00B0);
        check("rst_a", alu_a, 16'h0000);
        check("rst_b", alu_b, 16'h0000);
        check("rst_done", 16'(done), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", 16'(instr_ready), 16'h0000);
        @(posedge clk); #1;
        check("rel_ready_high", 16'(instr_ready), 16'h0001);
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000, "rst_reg");

        // ADDI r1,#0xFF: sign-extended immediate
        issue("addi", 16'h09FF, 16'hFFFF, 5'b00010, 8'h08, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        check_reg(3'd1, 16'hFFFF, "addi_r1");
        check("addi_psr", 16'(psr), 16'h0002);

        // ADDUI r2,#0x80 then ADD r2,r2 reading the fresh write-back
        issue("addui", 16'h1A80, 16'h0080, 5'b00000, 8'h18, 16'h0000, 16'h0080, 1'b1, 1'b0);
        check_reg(3'd2, 16'h0080, "addui_r2");
        issue("add_dep", 16'h0240, 16'h0100, 5'b00000, 8'h00, 16'h0080, 16'h0080, 1'b1, 1'b0);
        check_reg(3'd2, 16'h0100, "add_r2");

        issue("addui_r4", 16'h1C01, 16'h0001, 5'b00000, 8'h18, 16'h0000, 16'h0001, 1'b1, 1'b0);
        check_reg(3'd4, 16'h0001, "addui_r4");

        // CMP r1,r4: flags only, no register write
        issue("cmp", 16'h5180, 16'hBEEF, 5'b00011, 8'h50, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        check_reg(3'd1, 16'hFFFF, "cmp_r1");
        check("cmp_psr", 16'(psr), 16'h0003);

        // RSHI r4,#0xF3: only imm8[3:0] reaches B
        issue("rshi", 16'h9CF3, 16'h0000, 5'b10000, 8'h98, 16'h0001, 16'h0003, 1'b1, 1'b0);
        check_reg(3'd4, 16'h0000, "rshi_r4");
        check("rshi_psr", 16'(psr), 16'h0010);

        issue("nop", 16'hB100, 16'h1234, 5'b11111, 8'hB0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        check_reg(3'd1, 16'hFFFF, "nop_r1");
        check("nop_psr", 16'(psr), 16'h0010);

        // k=25 is undefined: illegal pulse, NOP opcode, no write-back
        issue("ill", 16'hCA00, 16'h5555, 5'b10101, 8'hB0, 16'h0100, 16'h0000, 1'b0, 1'b1);
        check_reg(3'd2, 16'h0100, "ill_r2");
        check("ill_psr", 16'(psr), 16'h0010);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            check("halt_ready", 16'(instr_ready), 16'h0000);
            @(posedge clk); #1;
        end
        check("halt_done", 16'(done), 16'h0000);
        do_reset();
`else
        check("ill_ready", 16'(instr_ready), 16'h0001);
`endif

        // Reset during EXEC of SUBI r3,#1 aborts with no partial write
        wait_ready("abort_ready");
        instr_valid = 1'b1;
        instr       = 16'h4B01;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_opc", 16'(alu_opcode), 16'h0048);
        check("abort_b", alu_b, 16'h0001);
        alu_c     = 16'h7777;
        alu_flags = 5'b00100;
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_done", 16'(done), 16'h0000);
        check("abort_ready_low", 16'(instr_ready), 16'h0000);
        check("abort_opc_nop", 16'(alu_opcode), 16'h00B0);
        check("abort_psr", 16'(psr), 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 16'(done), 16'h0000);
        end
        check("abort_ready_high", 16'(instr_ready), 16'h0001);
        check_reg(3'd3, 16'h0000, "abort_r3");
        check_reg(3'd1, 16'h0000, "abort_r1");

        issue("subi", 16'h4B01, 16'hFFFF, 5'b00010, 8'h48, 16'h0000, 16'h0001, 1'b1, 1'b0);
        check_reg(3'd3, 16'hFFFF, "subi_r3");
        check("subi_psr", 16'(psr), 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
